// File: rtl/slave_pkg.sv
// Shared definitions for the cmd/adr/data bus slave.
// Holds the command code enum, the FSM state enum, default widths
// and a helper classifying command codes as legal or illegal.
package slave_pkg;

  localparam int unsigned CMD_W      = 4;
  localparam int unsigned DW_DEF     = 4;
  localparam int unsigned AW_DEF     = 4;
  localparam int unsigned DROP_W_DEF = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP  = 4'd0,
    CMD_WR   = 4'd1,
    CMD_RD   = 4'd2,
    CMD_ADD  = 4'd3,
    CMD_CLR  = 4'd4,
    CMD_FILL = 4'd5
  } cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Codes above FILL have no meaning on this bus.
  function automatic logic cmd_legal(input logic [CMD_W-1:0] code);
    return (code <= 4'(CMD_FILL));
  endfunction

endpackage

// File: rtl/slave_regfile.sv
// Register file: 2**AW words of DW bits, synchronous clear on reset.
// Ports: clk, rst (sync, active-high), we/waddr/wdata write port,
//        raddr -> rdata_c combinational read port.
module slave_regfile #(
  parameter int unsigned DW = 4,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_c
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Single write port; reset clears every word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/dut_slave.sv
// Bus slave: executes one sampled command per clock edge against a
// 16x4 register file, with a multi-cycle FILL sequence.
// Ports: clk, rst (sync, active-high); cmd/adr/data command inputs;
//        rdata/rvalid read response; busy (FILL in progress);
//        err (illegal code pulse); ovf (ADD carry pulse);
//        drop_cnt (saturating count of commands dropped while busy).
module dut_slave
  import slave_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [AW-1:0]     adr,
  input  logic [DW-1:0]     data,
  output logic [DW-1:0]     rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              err,
  output logic              ovf,
  output logic [DROP_W-1:0] drop_cnt
);

  state_e        state;
  logic [AW-1:0] fill_ptr;
  logic [DW-1:0] fill_data;

  logic          we_c;
  logic [AW-1:0] waddr_c;
  logic [DW-1:0] wdata_c;
  logic [DW-1:0] rd_word_c;
  logic [DW:0]   sum_c;

  slave_regfile #(.DW(DW), .AW(AW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (we_c),
    .waddr   (waddr_c),
    .wdata   (wdata_c),
    .raddr   (adr),
    .rdata_c (rd_word_c)
  );

  // Extra top bit captures the ADD carry-out.
  assign sum_c = {1'b0, rd_word_c} + {1'b0, data};

  // Write mux: command path in IDLE, fill path while filling.
  always_comb begin
    we_c    = 1'b0;
    waddr_c = adr;
    wdata_c = data;
    if (state == ST_IDLE) begin
      case (cmd_e'(cmd))
        CMD_WR:   we_c = 1'b1;
        CMD_FILL: we_c = 1'b1;
        CMD_ADD: begin
          we_c    = 1'b1;
          wdata_c = sum_c[DW-1:0];
        end
        CMD_CLR: begin
          we_c    = 1'b1;
          wdata_c = '0;
        end
        default: we_c = 1'b0;
      endcase
    end else begin
      we_c    = 1'b1;
      waddr_c = fill_ptr;
      wdata_c = fill_data;
    end
  end

  // FSM, fill bookkeeping, pulse outputs and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fill_ptr  <= '0;
      fill_data <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
      case (state)
        ST_IDLE: begin
          case (cmd_e'(cmd))
            CMD_RD: begin
              rdata  <= rd_word_c;
              rvalid <= 1'b1;
            end
            CMD_ADD: ovf <= sum_c[DW];
            CMD_FILL: begin
              fill_data <= data;
              // Starting at the last word is a single write; no sequence.
              if (adr != {AW{1'b1}}) begin
                state    <= ST_FILL;
                fill_ptr <= adr + AW'(1);
              end
            end
            default: err <= ~cmd_legal(cmd);
          endcase
        end
        ST_FILL: begin
          fill_ptr <= fill_ptr + AW'(1);
          if (fill_ptr == {AW{1'b1}}) begin
            state <= ST_IDLE;
          end
          if (cmd != 4'(CMD_NOP) && drop_cnt != {DROP_W{1'b1}}) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_FILL);

endmodule

// File: doc/dut_slave.md
# dut_slave

Command-consuming end of the 4-bit cmd/adr/data bus.
- Samples `cmd`, `adr` and `data` on every rising clock edge and executes the command against a 16×4 register file.
- Returns read data, busy, error and overflow indications.
- Sits on the slave side of the bus interface; the master side drives it and the bus-side coverage samples the same signals.

## Interface

Parameters:
- `DW`, 4, data width.
- `AW`, 4, address width; register file depth is 2**AW.
- `DROP_W`, 8, width of the dropped-command counter.

Ports:
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `cmd`  input  4  command code, sampled every edge.
- `adr`  input  AW  command address.
- `data`  input  DW  command write/operand data.
- `rdata`  output  DW  read result, registered.
- `rvalid`  output  1  one-cycle pulse, `rdata` valid.
- `busy`  output  1  high while a FILL sequence is in progress.
- `err`  output  1  one-cycle pulse on an illegal command code.
- `ovf`  output  1  one-cycle pulse when ADD carries out.
- `drop_cnt`  output  DROP_W  count of commands dropped while busy; saturating.

## Operation

Command codes:
- 0 NOP
- 1 WR
- 2 RD
- 3 ADD
- 4 CLR
- 5 FILL
- 6–15 illegal

Commands apply at the sampling edge N, while the FSM is in IDLE:
- **WR:** mem[adr] <= data.
- **RD:** rdata <= mem[adr], using the value before edge N; rvalid <= 1.
- **ADD:** mem[adr] <= (mem[adr] + data) mod 2**DW; ovf <= carry out.
- **CLR:** mem[adr] <= 0.
- **FILL:**
  - mem[adr] <= data; latch data into `fill_data`.
  - If adr < 2**AW−1: go to FILL, `fill_ptr` <= adr+1.
  - Otherwise remain in IDLE.
- **Illegal code:** err <= 1; no other state changes.

FSM states:
- **IDLE:** executes commands as above.
- **FILL:**
  - Each edge: mem[fill_ptr] <= fill_data; fill_ptr <= fill_ptr+1.
  - When fill_ptr == 2**AW−1, write and return to IDLE.

While the FSM is in FILL:
- Any sampled cmd other than NOP is dropped: no memory access, no rvalid/err/ovf.
- Each dropped command increments drop_cnt by 1, saturating at 2**DROP_W−1.
- NOP is never counted.
- Illegal codes in FILL are counted as dropped; err stays 0.

Pulse outputs (rvalid, err, ovf) are low on any edge that does not set them.

Reset (rst high at an edge) overrides everything, including mid-FILL:
- All memory words = 0, FSM = IDLE, fill_ptr = 0.
- rdata = 0, rvalid = 0, busy = 0, err = 0, ovf = 0, drop_cnt = 0.

## Timing

- All outputs are registered and change only at rising edges.
- RD latency: 1 cycle. rdata/rvalid are visible after edge N and rvalid drops at N+1 unless another RD is sampled.
- Back-to-back RD is supported every cycle.
- Read-after-write: WR at edge N followed by RD at edge N+1 returns the new value. There is no same-edge hazard because only one command is sampled per edge.
- `busy` == (state == FILL).
- FILL at address a (< 2**AW−1) sampled at edge N:
  - Writes a at N and a+k at N+k.
  - Finishes at edge N+(2**AW−1−a).
  - busy is high between edge N and that final edge.
  - Commands sampled at edges N+1 .. N+(2**AW−1−a) are subject to the drop rule.
- FILL at address 2**AW−1: single write, busy never rises.
- drop_cnt updates at the same edge that samples the dropped command.

## Structure

- **Shared package `slave_pkg`:**
  - `cmd_e` enum with the 6 legal codes, plus a helper returning legal/illegal.
  - FSM state enum {IDLE, FILL}.
  - Default width constants.
- **Sub-module `slave_regfile`:**
  - 2**AW × DW array with synchronous reset-to-zero.
  - One write port (en, addr, data).
  - One combinational read port.
- The top level holds the FSM, fill_ptr/fill_data, the pulse registers and the drop counter.
- A single write mux selects between the command path (WR/ADD/CLR/FILL) and the fill path.

## Test plan

1. Reset, then RD adr=3 → one cycle later rdata=0, rvalid=1 for exactly one cycle; all other outputs 0.
2. WR adr=5 data=9, next cycle RD adr=5 → rdata=9. Then ADD adr=5 data=9, then RD → ovf pulses once, rdata=2.
3. FILL adr=12 data=7, followed by WR adr=0 data=1, RD adr=0, cmd=9 →
   - busy high exactly 3 cycles;
   - drop_cnt=3; no rvalid/err;
   - mem[12..15]=7, mem[11] and mem[0] unchanged (0).
4. cmd=9 in IDLE → err pulses once, memory unchanged. FILL adr=15 data=4 → mem[15]=4, busy never asserts. CLR adr=15, then RD → 0.
5. 300 non-NOP commands during repeated FILL adr=0 sequences → drop_cnt saturates at 255. NOPs during FILL do not increment it.
6. rst asserted at the second edge of FILL adr=8 data=3 → busy=0 after that edge, all memory reads return 0, drop_cnt=0. A new WR after reset executes normally.
